pipeline_id_stage: RTL and testbench
====================================

Name: pipeline_id_stage

Overview:
Parametrised decode stage for the 5-stage MIPS pipeline. It owns the IF/ID and ID/EX pipeline registers, detects load-use and branch-operand hazards, and forwards operands from MEM/WB into ID. It resolves branches and jumps in ID, with early redirect and IF/ID flush. The register file and main Control sit outside; this block drives the register-file read addresses and consumes the read data.

Parameters:
DATA_W, 32, datapath width (>=32)
PC_W, 32, PC width (>=28); jump target keeps the upper PC_W-28 bits of pc+4
MEM_FWD, 1, 1 = forward MEM-stage result into ID; 0 = ID sources only from WB and the register file (extra stall)
CNT_W, 16, width of the saturating stall-cycle counter

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
if_valid  in  1  fetch slot holds a real instruction
if_pc  in  PC_W  address of the fetched instruction
if_instr  in  32  fetched instruction
ex_ready  in  1  downstream accepts ID/EX this cycle
ex_memrd  in  1  instruction in EX is a load
ex_regwr  in  1  EX instruction writes a register
ex_wrreg  in  5  EX destination register
mem_memrd  in  1  instruction in MEM is a load
mem_regwr  in  1  MEM instruction writes a register
mem_wrreg  in  5  MEM destination register
mem_data  in  DATA_W  MEM ALU result
wb_regwr  in  1  WB writes a register
wb_wrreg  in  5  WB destination register
wb_data  in  DATA_W  WB write data
rf_raddr1  out  5  = IF/ID rs
rf_raddr2  out  5  = IF/ID rt
rf_rdata1  in  DATA_W  register-file port 1 data
rf_rdata2  in  DATA_W  register-file port 2 data
if_stall  out  1  hold PC and fetch
redirect  out  1  fetch from redirect_pc next cycle
redirect_pc  out  PC_W  branch or jump target
idex_valid  out  1  ID/EX holds a real instruction
idex_pc  out  PC_W  instruction address
idex_instr  out  32  instruction (0 when bubble)
idex_dataA  out  DATA_W  forwarded rs value
idex_dataB  out  DATA_W  forwarded rt value
idex_wrreg  out  5  rd for opcode 0, 31 for jal, else rt
stall_cnt  out  CNT_W  saturating count of hazard-stall cycles

Behaviour:
- Reset (sync): all registered outputs, including the IF/ID contents, are cleared to 0; stall_cnt=0.
- Decoded uses:
  - rs used by every opcode except j/jal/lui.
  - rt used by R-type, beq, bne and sw.
  - Register 0 never creates a hazard and is never forwarded.
- ID operand select, priority order:
  - MEM (only when MEM_FWD=1, mem_regwr, !mem_memrd, address match)
  - WB (wb_regwr, address match)
  - rf_rdata
- Hazard stall (hz=1) if the IF/ID instruction is valid and any of these holds:
  - load-use: ex_memrd, and ex_wrreg matches a used source.
  - branch/jr/jalr source matches ex_wrreg with ex_regwr. The value is not ready; this costs 1 cycle, or 2 cycles for a load.
  - branch/jr/jalr source matches mem_wrreg with mem_memrd.
  - MEM_FWD=0 only: any used source matches mem_wrreg with mem_regwr.
- adv = ex_ready & !hz.
- if_stall = !ex_ready | hz.
- On adv, ID/EX loads the decoded IF/ID contents.
- On ex_ready & hz, ID/EX loads a bubble (valid=0, instr=0) and IF/ID holds.
- On !ex_ready, both registers hold.
- Branch and jump resolution (combinational on ID operands):
  - bltz/beq/bne/blez/bgtz conditions use signed semantics on DATA_W.
  - Branch target = pc+4 + (sext(imm16)<<2), truncated to PC_W.
  - j/jal target = {pc4[PC_W-1:28], instr[25:0], 2'b00}.
  - jr/jalr target = dataA[PC_W-1:0].
- redirect = adv & (taken branch | jump). When redirect=1, IF/ID captures a bubble next cycle regardless of if_valid.
- Simultaneous events:
  - hz suppresses redirect.
  - Redirect and an incoming fetch: the flush wins.
- An instruction of all zeros is treated as a bubble: valid=0, no hazards.
- stall_cnt increments on each clk with ex_ready & hz and saturates at all-ones.
- Reset asserted mid-stall clears everything; the first post-reset fetch is captured normally.

Test Plan:
1. lw $8 then add $9,$8,$8 back-to-back → exactly 1 bubble: idex_valid=0 for one cycle, if_stall=1 for one cycle; add then enters with dataA = wb_data forwarded; stall_cnt=1.
2. addi $4 (result 5) then beq $4,$0 → 1-cycle stall; beq resolves not-taken using mem_data=5 (MEM_FWD=1); with MEM_FWD=0 it stalls 2 cycles and uses wb_data.
3. beq $2,$3 with rf 7/7 at pc 0x100, imm 0xFFFF → redirect=1 for one cycle, redirect_pc=0x100; next idex_instr=0 (flushed slot).
4. jal 0x40 at pc 0x00400000 → redirect_pc=0x00000100, idex_wrreg=31; jr $31 with rf 0x24 → redirect_pc=0x24.
5. ex_ready=0 for 3 cycles holding a taken beq → redirect stays 0, outputs frozen, stall_cnt unchanged; on release: single redirect pulse.
6. Reset during a load-use stall → next cycle all outputs 0 and stall_cnt=0; a following add is fetched with no stall.

Source files
------------

// File: rtl/pipeline_id_stage.sv
// Decode stage for the 5-stage MIPS pipeline. It holds the IF/ID and ID/EX
// pipeline registers and detects load-use and branch-operand hazards.
// It forwards MEM/WB results into ID and resolves branches and jumps in ID,
// with an early redirect and an IF/ID flush.
module pipeline_id_stage #(
  parameter int DATA_W  = 32,
  parameter int PC_W    = 32,
  parameter int MEM_FWD = 1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_valid,
  input  logic [PC_W-1:0]   if_pc,
  input  logic [31:0]       if_instr,
  input  logic              ex_ready,
  input  logic              ex_memrd,
  input  logic              ex_regwr,
  input  logic [4:0]        ex_wrreg,
  input  logic              mem_memrd,
  input  logic              mem_regwr,
  input  logic [4:0]        mem_wrreg,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              wb_regwr,
  input  logic [4:0]        wb_wrreg,
  input  logic [DATA_W-1:0] wb_data,
  output logic [4:0]        rf_raddr1,
  output logic [4:0]        rf_raddr2,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,
  output logic              if_stall,
  output logic              redirect,
  output logic [PC_W-1:0]   redirect_pc,
  output logic              idex_valid,
  output logic [PC_W-1:0]   idex_pc,
  output logic [31:0]       idex_instr,
  output logic [DATA_W-1:0] idex_dataA,
  output logic [DATA_W-1:0] idex_dataB,
  output logic [4:0]        idex_wrreg,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [5:0] {
    OP_RTYPE  = 6'h00,
    OP_REGIMM = 6'h01,
    OP_J      = 6'h02,
    OP_JAL    = 6'h03,
    OP_BEQ    = 6'h04,
    OP_BNE    = 6'h05,
    OP_BLEZ   = 6'h06,
    OP_BGTZ   = 6'h07,
    OP_LUI    = 6'h0F,
    OP_SW     = 6'h2B
  } opcode_e;

  typedef enum logic [5:0] {
    FN_JR   = 6'h08,
    FN_JALR = 6'h09
  } funct_e;

  // Pipeline registers
  logic              ifid_valid_q, ifid_valid_d;
  logic [PC_W-1:0]   ifid_pc_q, ifid_pc_d;
  logic [31:0]       ifid_instr_q, ifid_instr_d;
  logic              idex_valid_q, idex_valid_d;
  logic [PC_W-1:0]   idex_pc_q, idex_pc_d;
  logic [31:0]       idex_instr_q, idex_instr_d;
  logic [DATA_W-1:0] idex_dataA_q, idex_dataA_d;
  logic [DATA_W-1:0] idex_dataB_q, idex_dataB_d;
  logic [4:0]        idex_wrreg_q, idex_wrreg_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  // Decode signals
  logic [5:0]        op, funct;
  logic [4:0]        rs, rt, rd;
  logic [15:0]       imm;
  logic              id_real, rs_used, rt_used, is_branch, is_jr, is_jump, br_src;
  logic              hz, adv, take, cond;
  logic [DATA_W-1:0] dataA, dataB;
  logic              a_neg, a_zero;
  logic [PC_W-1:0]   pc4, pc4_hi, br_tgt, j_tgt, tgt;
  logic [4:0]        wrreg;

  // Field decode, source usage and hazard detection on the IF/ID instruction
  always_comb begin
    op     = ifid_instr_q[31:26];
    rs     = ifid_instr_q[25:21];
    rt     = ifid_instr_q[20:16];
    rd     = ifid_instr_q[15:11];
    funct  = ifid_instr_q[5:0];
    imm    = ifid_instr_q[15:0];
    // An all-zero word is a bubble even if the fetch slot claimed it valid
    id_real   = ifid_valid_q && (ifid_instr_q != '0);
    rs_used   = !(op == OP_J || op == OP_JAL || op == OP_LUI) && (rs != 5'd0);
    rt_used   = (op == OP_RTYPE || op == OP_BEQ || op == OP_BNE || op == OP_SW) && (rt != 5'd0);
    is_branch = (op == OP_REGIMM) || (op == OP_BEQ) || (op == OP_BNE) ||
                (op == OP_BLEZ) || (op == OP_BGTZ);
    is_jr     = (op == OP_RTYPE) && (funct == FN_JR || funct == FN_JALR);
    is_jump   = (op == OP_J) || (op == OP_JAL);
    br_src    = is_branch || is_jr;

    hz = 1'b0;
    if (id_real) begin
      if (ex_memrd && ((rs_used && rs == ex_wrreg) || (rt_used && rt == ex_wrreg)))
        hz = 1'b1;
      if (br_src && ex_regwr && ((rs_used && rs == ex_wrreg) || (rt_used && rt == ex_wrreg)))
        hz = 1'b1;
      if (br_src && mem_memrd && ((rs_used && rs == mem_wrreg) || (rt_used && rt == mem_wrreg)))
        hz = 1'b1;
      if ((MEM_FWD == 0) && mem_regwr &&
          ((rs_used && rs == mem_wrreg) || (rt_used && rt == mem_wrreg)))
        hz = 1'b1;
    end
    adv = ex_ready && !hz;
  end

  // Operand forwarding: MEM (non-load) first, then WB, then register file
  always_comb begin
    dataA = rf_rdata1;
    if ((MEM_FWD != 0) && mem_regwr && !mem_memrd && rs != 5'd0 && mem_wrreg == rs)
      dataA = mem_data;
    else if (wb_regwr && rs != 5'd0 && wb_wrreg == rs)
      dataA = wb_data;

    dataB = rf_rdata2;
    if ((MEM_FWD != 0) && mem_regwr && !mem_memrd && rt != 5'd0 && mem_wrreg == rt)
      dataB = mem_data;
    else if (wb_regwr && rt != 5'd0 && wb_wrreg == rt)
      dataB = wb_data;
  end

  // Branch condition, target selection and destination register
  always_comb begin
    a_neg  = dataA[DATA_W-1];
    a_zero = (dataA == '0);
    pc4    = ifid_pc_q + PC_W'(4);
    br_tgt = pc4 + {{(PC_W-18){imm[15]}}, imm, 2'b00};
    // Shifting keeps this legal when PC_W is exactly 28
    pc4_hi = (pc4 >> 28) << 28;
    j_tgt  = pc4_hi | PC_W'({ifid_instr_q[25:0], 2'b00});

    cond = 1'b0;
    unique case (op)
      OP_REGIMM: cond = (rt == 5'd0) && a_neg;
      OP_BEQ:    cond = (dataA == dataB);
      OP_BNE:    cond = (dataA != dataB);
      OP_BLEZ:   cond = a_neg || a_zero;
      OP_BGTZ:   cond = !a_neg && !a_zero;
      default:   cond = 1'b0;
    endcase

    tgt = br_tgt;
    if (is_jump)
      tgt = j_tgt;
    else if (is_jr)
      tgt = PC_W'(dataA);

    take = id_real && ((is_branch && cond) || is_jump || is_jr);

    if (op == OP_RTYPE)
      wrreg = rd;
    else if (op == OP_JAL)
      wrreg = 5'd31;
    else
      wrreg = rt;
  end

  // Next-state for IF/ID, ID/EX and the stall counter
  always_comb begin
    ifid_valid_d = ifid_valid_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    idex_valid_d = idex_valid_q;
    idex_pc_d    = idex_pc_q;
    idex_instr_d = idex_instr_q;
    idex_dataA_d = idex_dataA_q;
    idex_dataB_d = idex_dataB_q;
    idex_wrreg_d = idex_wrreg_q;
    stall_cnt_d  = stall_cnt_q;
    if (ex_ready) begin
      if (hz) begin
        idex_valid_d = 1'b0;
        idex_pc_d    = '0;
        idex_instr_d = '0;
        idex_dataA_d = '0;
        idex_dataB_d = '0;
        idex_wrreg_d = '0;
        if (stall_cnt_q != '1)
          stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end else begin
        idex_valid_d = id_real;
        idex_pc_d    = id_real ? ifid_pc_q : '0;
        idex_instr_d = id_real ? ifid_instr_q : '0;
        idex_dataA_d = id_real ? dataA : '0;
        idex_dataB_d = id_real ? dataB : '0;
        idex_wrreg_d = id_real ? wrreg : '0;
        // A taken redirect flushes the slot fetched down the wrong path
        if (take) begin
          ifid_valid_d = 1'b0;
          ifid_pc_d    = '0;
          ifid_instr_d = '0;
        end else begin
          ifid_valid_d = if_valid;
          ifid_pc_d    = if_valid ? if_pc : '0;
          ifid_instr_d = if_valid ? if_instr : '0;
        end
      end
    end
  end

  // Register update with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      ifid_valid_q <= 1'b0;
      ifid_pc_q    <= '0;
      ifid_instr_q <= '0;
      idex_valid_q <= 1'b0;
      idex_pc_q    <= '0;
      idex_instr_q <= '0;
      idex_dataA_q <= '0;
      idex_dataB_q <= '0;
      idex_wrreg_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      ifid_valid_q <= ifid_valid_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      idex_valid_q <= idex_valid_d;
      idex_pc_q    <= idex_pc_d;
      idex_instr_q <= idex_instr_d;
      idex_dataA_q <= idex_dataA_d;
      idex_dataB_q <= idex_dataB_d;
      idex_wrreg_q <= idex_wrreg_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign rf_raddr1   = rs;
  assign rf_raddr2   = rt;
  assign if_stall    = !ex_ready || hz;
  assign redirect    = adv && take;
  assign redirect_pc = tgt;
  assign idex_valid  = idex_valid_q;
  assign idex_pc     = idex_pc_q;
  assign idex_instr  = idex_instr_q;
  assign idex_dataA  = idex_dataA_q;
  assign idex_dataB  = idex_dataB_q;
  assign idex_wrreg  = idex_wrreg_q;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_id_stage.sv
// Directed bench for pipeline_id_stage. A MEM-forwarding instance with a
// 16-bit counter runs beside a no-MEM-forwarding instance with a 2-bit
// counter; both see the same inputs.
`timescale 1ns/1ps
module tb_pipeline_id_stage;

  localparam logic [31:0] LW   = 32'h8C28_0000; // lw   $8,0($1)
  localparam logic [31:0] ADD  = 32'h0108_4820; // add  $9,$8,$8
  localparam logic [31:0] ADDI = 32'h2004_0005; // addi $4,$0,5
  localparam logic [31:0] BEQ4 = 32'h1080_0003; // beq  $4,$0,3
  localparam logic [31:0] BEQ  = 32'h1043_FFFF; // beq  $2,$3,-1
  localparam logic [31:0] JAL  = 32'h0C00_0040; // jal  0x40
  localparam logic [31:0] JR   = 32'h03E0_0008; // jr   $31

  logic        clk = 1'b0;
  logic        reset;
  logic        if_valid;
  logic [31:0] if_pc, if_instr;
  logic        ex_ready, ex_memrd, ex_regwr;
  logic [4:0]  ex_wrreg;
  logic        mem_memrd, mem_regwr;
  logic [4:0]  mem_wrreg;
  logic [31:0] mem_data;
  logic        wb_regwr;
  logic [4:0]  wb_wrreg;
  logic [31:0] wb_data;
  logic [31:0] rf_rdata1, rf_rdata2;

  logic [4:0]  rf_raddr1, rf_raddr2, idex_wrreg;
  logic        if_stall, redirect, idex_valid;
  logic [31:0] redirect_pc, idex_pc, idex_instr, idex_dataA, idex_dataB;
  logic [15:0] stall_cnt;

  logic [4:0]  rf_raddr1_m0, rf_raddr2_m0, idex_wrreg_m0;
  logic        if_stall_m0, redirect_m0, idex_valid_m0;
  logic [31:0] redirect_pc_m0, idex_pc_m0, idex_instr_m0, idex_dataA_m0, idex_dataB_m0;
  logic [1:0]  stall_cnt_m0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipeline_id_stage #(.DATA_W(32), .PC_W(32), .MEM_FWD(1), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .ex_ready(ex_ready), .ex_memrd(ex_memrd), .ex_regwr(ex_regwr), .ex_wrreg(ex_wrreg),
    .mem_memrd(mem_memrd), .mem_regwr(mem_regwr), .mem_wrreg(mem_wrreg), .mem_data(mem_data),
    .wb_regwr(wb_regwr), .wb_wrreg(wb_wrreg), .wb_data(wb_data),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .if_stall(if_stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .idex_valid(idex_valid), .idex_pc(idex_pc), .idex_instr(idex_instr),
    .idex_dataA(idex_dataA), .idex_dataB(idex_dataB), .idex_wrreg(idex_wrreg),
    .stall_cnt(stall_cnt)
  );

  pipeline_id_stage #(.DATA_W(32), .PC_W(32), .MEM_FWD(0), .CNT_W(2)) dut_m0 (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .ex_ready(ex_ready), .ex_memrd(ex_memrd), .ex_regwr(ex_regwr), .ex_wrreg(ex_wrreg),
    .mem_memrd(mem_memrd), .mem_regwr(mem_regwr), .mem_wrreg(mem_wrreg), .mem_data(mem_data),
    .wb_regwr(wb_regwr), .wb_wrreg(wb_wrreg), .wb_data(wb_data),
    .rf_raddr1(rf_raddr1_m0), .rf_raddr2(rf_raddr2_m0), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .if_stall(if_stall_m0), .redirect(redirect_m0), .redirect_pc(redirect_pc_m0),
    .idex_valid(idex_valid_m0), .idex_pc(idex_pc_m0), .idex_instr(idex_instr_m0),
    .idex_dataA(idex_dataA_m0), .idex_dataB(idex_dataB_m0), .idex_wrreg(idex_wrreg_m0),
    .stall_cnt(stall_cnt_m0)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_env();
    if_valid = 1'b0; if_pc = '0; if_instr = '0;
    ex_ready = 1'b1; ex_memrd = 1'b0; ex_regwr = 1'b0; ex_wrreg = '0;
    mem_memrd = 1'b0; mem_regwr = 1'b0; mem_wrreg = '0; mem_data = '0;
    wb_regwr = 1'b0; wb_wrreg = '0; wb_data = '0;
    rf_rdata1 = '0; rf_rdata2 = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clr_env();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    clr_env();
    tick();
    do_reset();
    #1;
    check("rst_idex_valid", idex_valid, 0);
    check("rst_idex_instr", idex_instr, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_if_stall", if_stall, 0);
    check("rst_redirect", redirect, 0);

    // 1: load-use costs exactly one bubble; add then takes WB data
    if_valid = 1'b1; if_pc = 32'h0; if_instr = LW;
    tick();
    if_pc = 32'h4; if_instr = ADD; #1;
    check("t1_lw_no_stall", if_stall, 0);
    check("t1_raddr1_lw", rf_raddr1, 1);
    tick();
    check("t1_idex_lw_wrreg", idex_wrreg, 8);
    ex_memrd = 1'b1; ex_regwr = 1'b1; ex_wrreg = 5'd8;
    if_pc = 32'h8; if_instr = 32'h0; #1;
    check("t1_stall", if_stall, 1);
    check("t1_raddr1_add", rf_raddr1, 8);
    tick();
    check("t1_bubble_valid", idex_valid, 0);
    check("t1_bubble_instr", idex_instr, 0);
    check("t1_stall_cnt", stall_cnt, 1);
    ex_memrd = 1'b0; ex_regwr = 1'b0; ex_wrreg = '0;
    mem_memrd = 1'b1; mem_regwr = 1'b1; mem_wrreg = 5'd8; mem_data = 32'hDEAD;
    wb_regwr = 1'b1; wb_wrreg = 5'd8; wb_data = 32'hAAAA;
    rf_rdata1 = 32'h1111; rf_rdata2 = 32'h2222; #1;
    check("t1_release", if_stall, 0);
    tick();
    check("t1_add_valid", idex_valid, 1);
    check("t1_add_instr", idex_instr, ADD);
    check("t1_add_pc", idex_pc, 32'h4);
    check("t1_add_dataA", idex_dataA, 32'hAAAA);
    check("t1_add_dataB", idex_dataB, 32'hAAAA);
    check("t1_add_wrreg", idex_wrreg, 9);
    check("t1_stall_cnt_end", stall_cnt, 1);

    // 2: addi then beq on its result, with and without MEM forwarding
    do_reset();
    if_valid = 1'b1; if_pc = 32'h20; if_instr = ADDI;
    tick();
    if_pc = 32'h24; if_instr = BEQ4;
    tick();
    ex_regwr = 1'b1; ex_wrreg = 5'd4;
    if_pc = 32'h28; if_instr = 32'h0; #1;
    check("t2_stall_ex", if_stall, 1);
    check("t2_stall_ex_m0", if_stall_m0, 1);
    check("t2_raddr1", rf_raddr1, 4);
    tick();
    ex_regwr = 1'b0; ex_wrreg = '0;
    mem_regwr = 1'b1; mem_wrreg = 5'd4; mem_data = 32'd5; #1;
    check("t2_memfwd_go", if_stall, 0);
    check("t2_not_taken", redirect, 0);
    check("t2_m0_stall_mem", if_stall_m0, 1);
    tick();
    check("t2_beq_instr", idex_instr, BEQ4);
    check("t2_beq_dataA", idex_dataA, 5);
    check("t2_beq_pc", idex_pc, 32'h24);
    check("t2_beq_wrreg", idex_wrreg, 0);
    check("t2_stall_cnt", stall_cnt, 1);
    check("t2_m0_bubble", idex_valid_m0, 0);
    check("t2_m0_stall_cnt1", stall_cnt_m0, 2);
    mem_regwr = 1'b0; mem_wrreg = '0; mem_data = '0;
    wb_regwr = 1'b1; wb_wrreg = 5'd4; wb_data = 32'd5;
    if_valid = 1'b0; #1;
    check("t2_m0_go", if_stall_m0, 0);
    check("t2_m0_not_taken", redirect_m0, 0);
    tick();
    check("t2_m0_beq_instr", idex_instr_m0, BEQ4);
    check("t2_m0_beq_dataA", idex_dataA_m0, 5);
    check("t2_m0_stall_cnt", stall_cnt_m0, 2);
    check("t2_nop_bubble", idex_valid, 0);

    // 3: taken beq redirects to itself and flushes the next fetch
    do_reset();
    if_valid = 1'b1; if_pc = 32'h100; if_instr = BEQ;
    tick();
    if_pc = 32'h104; if_instr = ADD;
    rf_rdata1 = 32'd7; rf_rdata2 = 32'd7; #1;
    check("t3_redirect", redirect, 1);
    check("t3_redirect_pc", redirect_pc, 32'h100);
    check("t3_no_stall", if_stall, 0);
    tick();
    check("t3_beq_instr", idex_instr, BEQ);
    check("t3_beq_wrreg", idex_wrreg, 3);
    check("t3_pulse_end", redirect, 0);
    if_valid = 1'b0;
    tick();
    check("t3_flush_valid", idex_valid, 0);
    check("t3_flush_instr", idex_instr, 0);

    // 4: jal target, link register, then jr
    do_reset();
    if_valid = 1'b1; if_pc = 32'h0040_0000; if_instr = JAL;
    tick();
    if_pc = 32'h0040_0004; if_instr = ADD; #1;
    check("t4_jal_redirect", redirect, 1);
    check("t4_jal_pc", redirect_pc, 32'h0000_0100);
    tick();
    check("t4_jal_wrreg", idex_wrreg, 31);
    check("t4_jal_valid", idex_valid, 1);
    check("t4_flush_redirect", redirect, 0);
    if_pc = 32'h100; if_instr = JR;
    tick();
    if_valid = 1'b0; rf_rdata1 = 32'h24; #1;
    check("t4_jr_redirect", redirect, 1);
    check("t4_jr_pc", redirect_pc, 32'h24);
    tick();
    check("t4_jr_instr", idex_instr, JR);
    check("t4_jr_dataA", idex_dataA, 32'h24);

    // 5: downstream back-pressure holds a taken beq
    do_reset();
    if_valid = 1'b1; if_pc = 32'hFC; if_instr = ADD;
    tick();
    if_pc = 32'h100; if_instr = BEQ;
    tick();
    ex_ready = 1'b0; rf_rdata1 = 32'd7; rf_rdata2 = 32'd7;
    if_pc = 32'h104; if_instr = ADD;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t5_hold_redirect", redirect, 0);
      check("t5_hold_stall", if_stall, 1);
      check("t5_hold_instr", idex_instr, ADD);
      check("t5_hold_cnt", stall_cnt, 0);
      tick();
    end
    ex_ready = 1'b1; #1;
    check("t5_release_redirect", redirect, 1);
    check("t5_release_pc", redirect_pc, 32'h100);
    tick();
    check("t5_single_pulse", redirect, 0);
    check("t5_beq_instr", idex_instr, BEQ);
    check("t5_beq_dataA", idex_dataA, 7);
    if_valid = 1'b0;
    tick();
    check("t5_flush_instr", idex_instr, 0);

    // 6: reset in the middle of a load-use stall; counter saturation
    do_reset();
    if_valid = 1'b1; if_pc = 32'h0; if_instr = ADD;
    tick();
    ex_memrd = 1'b1; ex_regwr = 1'b1; ex_wrreg = 5'd8;
    if_pc = 32'h4; if_instr = LW;
    for (int i = 0; i < 4; i++) tick();
    check("t6_stall_cnt", stall_cnt, 4);
    check("t6_m0_saturated", stall_cnt_m0, 3);
    check("t6_still_stalled", if_stall, 1);
    do_reset();
    #1;
    check("t6_rst_valid", idex_valid, 0);
    check("t6_rst_instr", idex_instr, 0);
    check("t6_rst_pc", idex_pc, 0);
    check("t6_rst_dataA", idex_dataA, 0);
    check("t6_rst_wrreg", idex_wrreg, 0);
    check("t6_rst_cnt", stall_cnt, 0);
    check("t6_rst_cnt_m0", stall_cnt_m0, 0);
    check("t6_rst_raddr1", rf_raddr1, 0);
    check("t6_rst_if_stall", if_stall, 0);
    if_valid = 1'b1; if_pc = 32'h0; if_instr = ADD;
    tick();
    if_valid = 1'b0; #1;
    check("t6_add_no_stall", if_stall, 0);
    tick();
    check("t6_add_instr", idex_instr, ADD);
    check("t6_add_valid", idex_valid, 1);
    check("t6_cnt_after", stall_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
